add_share_arb: RTL and testbench
================================

# add_share_arb

Round-robin arbiter and sequencer that shares one 32-bit adder (`fullAdder`: sum = A+B mod 2^32, carry-out) among N requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one request per cycle, registers the adder result with carry and signed-overflow flags, and returns it with the requester ID on a single response channel that holds under back-pressure. It sits between the lab ALU clients and the shared adder datapath.

## Interface
- `N`, 4: number of requesters, 2..8.
- `W`, 32: operand width, fixed to match the shared adder.
- `IDW`, $clog2(N): width of the requester ID.

- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  reset, asynchronous and active-high.
- `req_valid`  in  N  bit i high means requester i has operands pending.
- `req_a`  in  N*W  requester i operand A at bits [i*W +: W].
- `req_b`  in  N*W  requester i operand B at bits [i*W +: W].
- `req_ready`  out  N  one-hot or zero; bit i high means requester i is accepted this cycle.
- `resp_valid`  out  1  response registers hold a result.
- `resp_ready`  in  1  consumer accepts the response.
- `resp_sum`  out  W  A+B mod 2^W.
- `resp_cout`  out  1  unsigned carry-out.
- `resp_ovf`  out  1  signed overflow: A[W-1]==B[W-1] and sum[W-1]!=A[W-1].
- `resp_id`  out  IDW  index of the requester that produced the result.

## Operation
- States: IDLE (no result held) and HOLD (result held, `resp_valid`=1).
- `can_accept` = (state==IDLE) | (state==HOLD & resp_ready).
- Grant selection:
  - Search `req_valid` starting at index `ptr`, wrapping modulo N.
  - First set bit wins and becomes `gnt`.
  - `req_ready` = onehot(gnt) when `can_accept` and any `req_valid` is set; otherwise 0.
  - `req_ready` is combinational from `req_valid`, `ptr`, state and `resp_ready`.
- On a handshake (req_valid[g] & req_ready[g]) at the clock edge:
  - register the adder output for `req_a[g]` and `req_b[g]`, plus the derived cout and ovf;
  - `resp_id`<=g;
  - `ptr`<=(g+1) mod N;
  - state<=HOLD.
- HOLD with resp_ready=1 and no new grant: state<=IDLE, `resp_valid`<=0, data registers keep their last values.
- HOLD with resp_ready=0: every response output stays stable and `req_ready`=0.
- IDLE with no valid requests: no change.
- Requesters must keep `req_valid` and operands stable until accepted. Dropping valid early withdraws the request with no side effect.
- Arithmetic is two's-complement agnostic. `resp_cout` and `resp_ovf` are both always reported; the consumer chooses which one applies.

## Timing
- Reset values: state=IDLE, `ptr`=0, `resp_valid`=0, `resp_sum`=0, `resp_cout`=0, `resp_ovf`=0, `resp_id`=0. `req_ready`=0 while `rst` is high.
- Latency: the response is visible in the cycle after the accepting edge (1 cycle).
- Throughput: 1 result per cycle while `resp_ready` stays high (back-to-back HOLD→HOLD).
- Pointer updates only on a grant. Requesters that stay valid are served in strict rotation, so any persistently valid requester waits at most N-1 grants.
- Simultaneous response accept and new grant in HOLD: the new result overwrites the registers with no bubble, and `resp_valid` stays 1.
- Reset mid-operation: a held result is discarded immediately (asynchronous) and no handshake completes on that edge.
- Wrap-around: `ptr`=N-1 with grant to N-1 gives `ptr`=0. With N not a power of 2, `ptr` never takes values ≥N.

## Structure
- Shared package `add_share_pkg`: state encoding (IDLE=1'b0, HOLD=1'b1) and the default constants `ADD_W`=32 and `ADD_N`=4.
- Sub-module `rr_pick`: combinational, parameterised by N. Inputs `req_valid` and `ptr`; outputs `gnt` index and `any`.
- The top level instantiates one `fullAdder` on muxed operands, the response registers and the state/pointer flops.

## Test plan
- Reset then idle: assert `rst` mid-HOLD → `resp_valid`=0 and all outputs 0 within the same cycle; after release, `ptr`=0.
- Single request: req 2 with A=3, B=4 → `req_ready`=4'b0100 that cycle; next cycle resp_sum=7, cout=0, ovf=0, id=2.
- Signed cases:
  - A=32'hFFFFFFFB, B=3 → sum 32'hFFFFFFFE, cout=0, ovf=0.
  - A=32'hFFFFFFFE, B=32'hFFFFFFFD → sum 32'hFFFFFFFB, cout=1, ovf=0.
  - A=32'h7FFFFFFF, B=1 → sum 32'h80000000, ovf=1.
- Round-robin: all 4 requesters valid continuously with resp_ready=1 → ids 0,1,2,3,0 on consecutive cycles, no bubbles.
- Back-pressure: resp_ready=0 for 3 cycles while req 1 is valid → response stable and `req_ready`=0; on resp_ready=1, req 1 is granted the same cycle and its result appears next cycle.
- Zeros and wrap: A=0, B=0 from req 3 with ptr=3 → sum 0, id=3, `ptr` becomes 0.

Source files
------------

// File: rtl/add_share_pkg.sv
// Shared definitions for the shared-adder arbiter: FSM encoding and default sizes.
package add_share_pkg;

  localparam int ADD_W = 32;
  localparam int ADD_N = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/add_share_arb_if.sv
// Request/response bundle between the ALU clients and the shared-adder arbiter.
interface add_share_arb_if
  import add_share_pkg::*;
#(
  parameter int N   = ADD_N,
  parameter int W   = ADD_W,
  parameter int IDW = $clog2(N)
);

  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic           resp_valid;
  logic           resp_ready;
  logic [W-1:0]   resp_sum;
  logic           resp_cout;
  logic           resp_ovf;
  logic [IDW-1:0] resp_id;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_sum, resp_cout, resp_ovf, resp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_sum, resp_cout, resp_ovf, resp_id
  );

endinterface

// File: rtl/add_share_arb_rr_pick.sv
// Round-robin search: first valid requester at or after ptr, wrapping modulo N.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req_valid,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] gnt,
  output logic           any
);

  logic [IDW:0] idx_s;

  // Walk N offsets from ptr; the earliest hit in rotation order wins.
  always_comb begin
    gnt   = '0;
    any   = 1'b0;
    idx_s = '0;
    for (int k = 0; k < N; k++) begin
      idx_s = {1'b0, ptr} + (IDW+1)'(k);
      idx_s = (idx_s >= (IDW+1)'(N)) ? idx_s - (IDW+1)'(N) : idx_s;
      if (!any && req_valid[idx_s[IDW-1:0]]) begin
        gnt = idx_s[IDW-1:0];
        any = 1'b1;
      end else begin
        gnt = gnt;
      end
    end
  end

endmodule

// File: rtl/fullAdder.sv
// Shared W-bit adder datapath: sum modulo 2^W plus unsigned carry-out.
module fullAdder #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/add_share_arb.sv
// Round-robin arbiter sharing one adder among N requesters, with a single
// registered response channel that holds under back-pressure.
module add_share_arb
  import add_share_pkg::*;
#(
  parameter int N   = ADD_N,
  parameter int W   = ADD_W,
  parameter int IDW = $clog2(N)
) (
  input logic            clk,
  input logic            rst,
  add_share_arb_if.slave bus
);

  localparam logic [IDW-1:0] LAST_ID = IDW'(N-1);

  state_t         state_r, state_nxt_s;
  logic [IDW-1:0] ptr_r, gnt_s, ptr_nxt_s, id_r;
  logic           any_s, can_accept_s, accept_s;
  logic [N-1:0]   req_ready_s;
  logic [W-1:0]   a_s, b_s, sum_s, sum_r;
  logic           cout_s, ovf_s, cout_r, ovf_r;

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req_valid (bus.req_valid),
    .ptr       (ptr_r),
    .gnt       (gnt_s),
    .any       (any_s)
  );

  // Steer the granted requester's operands onto the shared adder.
  always_comb begin
    a_s = '0;
    b_s = '0;
    for (int i = 0; i < N; i++) begin
      a_s = (gnt_s == IDW'(i)) ? bus.req_a[i*W +: W] : a_s;
      b_s = (gnt_s == IDW'(i)) ? bus.req_b[i*W +: W] : b_s;
    end
  end

  fullAdder #(.W(W)) u_add (
    .a    (a_s),
    .b    (b_s),
    .sum  (sum_s),
    .cout (cout_s)
  );

  assign ovf_s     = (a_s[W-1] == b_s[W-1]) && (sum_s[W-1] != a_s[W-1]);
  assign ptr_nxt_s = (gnt_s == LAST_ID) ? '0 : gnt_s + IDW'(1);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state: a grant always leads to HOLD; an accepted result with no grant drains to IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = accept_s ? HOLD : IDLE;
      HOLD:    state_nxt_s = (accept_s || !bus.resp_ready) ? HOLD : IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Grant outputs; reset is gated in so no requester sees ready while the block is held in reset.
  always_comb begin
    can_accept_s = (state_r == IDLE) || ((state_r == HOLD) && bus.resp_ready);
    accept_s     = can_accept_s && any_s && !rst;
    req_ready_s  = '0;
    for (int i = 0; i < N; i++) begin
      req_ready_s[i] = accept_s && (gnt_s == IDW'(i));
    end
  end

  // Response and pointer registers, loaded only on a completed handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
      id_r   <= '0;
      ptr_r  <= '0;
    end else if (accept_s) begin
      sum_r  <= sum_s;
      cout_r <= cout_s;
      ovf_r  <= ovf_s;
      id_r   <= gnt_s;
      ptr_r  <= ptr_nxt_s;
    end else begin
      sum_r  <= sum_r;
      cout_r <= cout_r;
      ovf_r  <= ovf_r;
      id_r   <= id_r;
      ptr_r  <= ptr_r;
    end
  end

  assign bus.req_ready  = req_ready_s;
  assign bus.resp_valid = (state_r == HOLD);
  assign bus.resp_sum   = sum_r;
  assign bus.resp_cout  = cout_r;
  assign bus.resp_ovf   = ovf_r;
  assign bus.resp_id    = id_r;

endmodule

// File: tb/tb_add_share_arb.sv
// Scoreboard bench for add_share_arb: directed grants push expected results,
// a negedge monitor compares whatever the response channel presents.
module tb_add_share_arb;

  localparam int N = 4;
  localparam int W = 32;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic [1:0]  id;
  } resp_t;

  logic clk;
  logic rst;
  logic [31:0] op_a [N];
  logic [31:0] op_b [N];
  resp_t q [$];
  int n_checks;
  int n_fail;

  add_share_arb_if #(.N(N), .W(W)) bus ();

  add_share_arb #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    bus.req_a = '0;
    bus.req_b = '0;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*W +: W] = op_a[i];
      bus.req_b[i*W +: W] = op_b[i];
    end
  end

  // Monitor: the front of the queue must match any presented response; pop on accept.
  always @(negedge clk) begin
    if (!rst && bus.resp_valid) begin
      n_checks++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_resp: got sum=%h id=%0d, expected no response", bus.resp_sum, bus.resp_id);
      end else begin
        if ({bus.resp_sum, bus.resp_cout, bus.resp_ovf, bus.resp_id} !== q[0]) begin
          n_fail++;
          $display("FAIL resp: got sum=%h cout=%b ovf=%b id=%0d, expected sum=%h cout=%b ovf=%b id=%0d",
                   bus.resp_sum, bus.resp_cout, bus.resp_ovf, bus.resp_id,
                   q[0].sum, q[0].cout, q[0].ovf, q[0].id);
        end
        if (bus.resp_ready) void'(q.pop_front());
      end
    end
  end

  task automatic chk(input logic [3:0] v, input logic rr, input logic [3:0] erdy,
                     input int idx, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] es, input logic ec, input logic eo);
    @(posedge clk);
    #1;
    if (erdy != 4'b0000) begin
      op_a[idx] = a;
      op_b[idx] = b;
    end
    bus.req_valid  = v;
    bus.resp_ready = rr;
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== erdy) begin
      n_fail++;
      $display("FAIL req_ready: got %b, expected %b (valid=%b)", bus.req_ready, erdy, v);
    end
    if (erdy != 4'b0000) q.push_back('{sum: es, cout: ec, ovf: eo, id: 2'(idx)});
  endtask

  task automatic drain();
    chk(4'b0000, 1'b1, 4'b0000, 0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk(4'b0000, 1'b1, 4'b0000, 0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    n_checks++;
    if (bus.resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_idle: resp_valid got %b, expected 0", bus.resp_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < N; i++) begin
      op_a[i] = 32'(i + 1);
      op_b[i] = 32'd10;
    end
    rst            = 1'b1;
    bus.req_valid  = 4'b1111;
    bus.resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL ready_in_reset: got %b, expected 0000", bus.req_ready);
    end
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.req_valid = 4'b0000;
    @(negedge clk);
    n_checks++;
    if ({bus.resp_valid, bus.resp_sum, bus.resp_cout, bus.resp_ovf, bus.resp_id} !== 37'd0) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%b sum=%h cout=%b ovf=%b id=%0d, expected all 0",
               bus.resp_valid, bus.resp_sum, bus.resp_cout, bus.resp_ovf, bus.resp_id);
    end

    // Round-robin with all requesters valid, no bubbles.
    chk(4'b1111, 1'b1, 4'b0001, 0, 32'd1, 32'd10, 32'd11, 1'b0, 1'b0);
    chk(4'b1111, 1'b1, 4'b0010, 1, 32'd2, 32'd10, 32'd12, 1'b0, 1'b0);
    chk(4'b1111, 1'b1, 4'b0100, 2, 32'd3, 32'd10, 32'd13, 1'b0, 1'b0);
    chk(4'b1111, 1'b1, 4'b1000, 3, 32'd4, 32'd10, 32'd14, 1'b0, 1'b0);
    chk(4'b1111, 1'b1, 4'b0001, 0, 32'd1, 32'd10, 32'd11, 1'b0, 1'b0);
    drain();

    // Single request from requester 2.
    chk(4'b0100, 1'b1, 4'b0100, 2, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0);
    drain();

    // Zeros from requester 3 at ptr=3, then ptr must have wrapped to 0.
    chk(4'b1000, 1'b1, 4'b1000, 3, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk(4'b1111, 1'b1, 4'b0001, 0, 32'd9, 32'd9, 32'd18, 1'b0, 1'b0);
    drain();

    // Signed / carry corner cases, back-to-back.
    chk(4'b0001, 1'b1, 4'b0001, 0, 32'hFFFFFFFB, 32'h00000003, 32'hFFFFFFFE, 1'b0, 1'b0);
    chk(4'b0010, 1'b1, 4'b0010, 1, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFB, 1'b1, 1'b0);
    chk(4'b0100, 1'b1, 4'b0100, 2, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1);
    chk(4'b1000, 1'b1, 4'b1000, 3, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1);
    drain();

    // Back-pressure: result held for 3 cycles while requester 1 waits.
    chk(4'b0001, 1'b0, 4'b0001, 0, 32'd100, 32'd23, 32'd123, 1'b0, 1'b0);
    op_a[1] = 32'd1000;
    op_b[1] = 32'd234;
    repeat (3) chk(4'b0010, 1'b0, 4'b0000, 1, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk(4'b0010, 1'b1, 4'b0010, 1, 32'd1000, 32'd234, 32'd1234, 1'b0, 1'b0);
    drain();

    // Reset asserted mid-HOLD clears outputs at once.
    op_a[1] = 32'd5;
    op_b[1] = 32'd6;
    chk(4'b0010, 1'b0, 4'b0010, 1, 32'd5, 32'd6, 32'd11, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.resp_valid, bus.resp_sum, bus.resp_cout, bus.resp_ovf, bus.resp_id, bus.req_ready} !== 41'd0) begin
      n_fail++;
      $display("FAIL async_reset: got valid=%b sum=%h cout=%b ovf=%b id=%0d ready=%b, expected all 0",
               bus.resp_valid, bus.resp_sum, bus.resp_cout, bus.resp_ovf, bus.resp_id, bus.req_ready);
    end
    q.delete();
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.req_valid = 4'b0000;
    chk(4'b1111, 1'b1, 4'b0001, 0, 32'd9, 32'd9, 32'd18, 1'b0, 1'b0);
    drain();

    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_empty: got %0d pending, expected 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
